// File: rtl/alu_req_sequencer.sv
// Sequential front end for the combinational ALU: accepts tagged requests, holds
// operands on the ALU ports for a programmable settle time, then returns the result.
module alu_req_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_in_1,
    input  logic [31:0]      req_in_2,
    input  logic [4:0]       req_aluop,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_in_1,
    output logic [31:0]      alu_in_2,
    output logic [4:0]       alu_aluop,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        alu_in_1_q, alu_in_1_d;
    logic [31:0]        alu_in_2_q, alu_in_2_d;
    logic [4:0]         alu_aluop_q, alu_aluop_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    function automatic logic op_legal(input logic [4:0] op);
        return (op == 5'd1) || (op == 5'd2) || ((op >= 5'd5) && (op <= 5'd16));
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_in_1_d   = alu_in_1_q;
        alu_in_2_d   = alu_in_2_q;
        alu_aluop_d  = alu_aluop_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rsp_tag_d = req_tag;
                    if (op_legal(req_aluop)) begin
                        alu_in_1_d  = req_in_1;
                        alu_in_2_d  = req_in_2;
                        alu_aluop_d = req_aluop;
                        cnt_d       = SETTLE_LOAD;
                        state_d     = SETTLE;
                    end else begin
                        // Rejected opcodes never touch the ALU ports.
                        rsp_result_d = 32'd0;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            alu_in_1_q   <= 32'd0;
            alu_in_2_q   <= 32'd0;
            alu_aluop_q  <= 5'd0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_in_1_q   <= alu_in_1_d;
            alu_in_2_q   <= alu_in_2_d;
            alu_aluop_q  <= alu_aluop_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign alu_in_1   = alu_in_1_q;
    assign alu_in_2   = alu_in_2_q;
    assign alu_aluop  = alu_aluop_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Self-checking bench: two sequencers (settle 1 with a 4-bit counter, settle 4 with a
// 16-bit counter), each wired to an adder stub standing in for the ALU.
module tb_alu_req_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [2];
    logic        req_valid  [2];
    logic [31:0] req_in_1   [2];
    logic [31:0] req_in_2   [2];
    logic [4:0]  req_aluop  [2];
    logic [3:0]  req_tag    [2];
    logic        rsp_ready  [2];
    logic [31:0] perturb    [2];
    wire         req_ready  [2];
    wire  [31:0] alu_in_1   [2];
    wire  [31:0] alu_in_2   [2];
    wire  [4:0]  alu_aluop  [2];
    wire  [31:0] alu_result [2];
    wire         rsp_valid  [2];
    wire  [31:0] rsp_result [2];
    wire  [3:0]  rsp_tag    [2];
    wire         rsp_err    [2];
    wire  [15:0] op_count   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int S  = (g == 0) ? 1 : 4;
        localparam int CW = (g == 0) ? 4 : 16;
        wire [CW-1:0] cnt_w;

        alu_req_sequencer #(.SETTLE_CYCLES(S), .TAG_W(4), .CNT_W(CW)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_in_1   (req_in_1[g]),
            .req_in_2   (req_in_2[g]),
            .req_aluop  (req_aluop[g]),
            .req_tag    (req_tag[g]),
            .alu_in_1   (alu_in_1[g]),
            .alu_in_2   (alu_in_2[g]),
            .alu_aluop  (alu_aluop[g]),
            .alu_result (alu_result[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_result (rsp_result[g]),
            .rsp_tag    (rsp_tag[g]),
            .rsp_err    (rsp_err[g]),
            .op_count   (cnt_w)
        );

        // ALU stub is a plain adder; perturb lets the bench wiggle it during backpressure.
        assign alu_result[g] = alu_in_1[g] + alu_in_2[g] + perturb[g];
        assign op_count[g]   = 16'(cnt_w);
    end

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: what the ALU ports should hold and how many responses completed.
    logic [31:0] last_a  [2];
    logic [31:0] last_b  [2];
    logic [4:0]  last_op [2];
    int          exp_count   [2];
    int          last_accept [2];

    function automatic int settleOf(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int countMod(input int d);
        return (d == 0) ? 16 : 65536;
    endfunction

    function automatic bit isLegal(input logic [4:0] op);
        return op inside {5'd1, 5'd2, [5'd5:5'd16]};
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [3:0]  tag;
        int          stall;
        logic        exp_err;
        logic [31:0] exp_res;
    } vec_t;

    // Single comparison point: every check bumps total and, on agreement, passed.
    task automatic checkOutput(input string name, input int d, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s (dut%0d): got %0h expected %0h at cycle %0d",
                      name, d, act, exp, cyc);
    endtask

    // Pulse reset on one instance and confirm every output returns to its reset value.
    task automatic resetDut(input int d);
        rst[d] = 1'b1; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0; perturb[d] = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst[d] = 1'b0;
        last_a[d] = 32'd0; last_b[d] = 32'd0; last_op[d] = 5'd0; exp_count[d] = 0;
        checkOutput("reset_alu_in_1", d, alu_in_1[d], 32'd0);
        checkOutput("reset_alu_in_2", d, alu_in_2[d], 32'd0);
        checkOutput("reset_alu_aluop", d, 32'(alu_aluop[d]), 32'd0);
        checkOutput("reset_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
        checkOutput("reset_rsp_err", d, 32'(rsp_err[d]), 32'd0);
        checkOutput("reset_rsp_result", d, rsp_result[d], 32'd0);
        checkOutput("reset_rsp_tag", d, 32'(rsp_tag[d]), 32'd0);
        checkOutput("reset_op_count", d, 32'(op_count[d]), 32'd0);
        checkOutput("reset_req_ready", d, 32'(req_ready[d]), 32'd1);
    endtask

    // One full transaction: request, settle window, optional backpressure, handshake.
    task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] op, input logic [3:0] tag,
                                 input int stall, input logic exp_err,
                                 input logic [31:0] exp_res);
        int waited = 0;
        while (req_ready[d] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("req_ready_before_req", d, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_in_1[d] = a; req_in_2[d] = b;
        req_aluop[d] = op; req_tag[d] = tag; rsp_ready[d] = 1'b0;
        @(posedge clk);
        last_accept[d] = cyc;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_in_1[d] = $urandom; req_in_2[d] = $urandom;
        req_aluop[d] = 5'($urandom); req_tag[d] = 4'($urandom);
        if (!exp_err) begin
            last_a[d] = a; last_b[d] = b; last_op[d] = op;
        end
        checkOutput("alu_in_1_after_accept", d, alu_in_1[d], last_a[d]);
        checkOutput("alu_in_2_after_accept", d, alu_in_2[d], last_b[d]);
        checkOutput("alu_aluop_after_accept", d, 32'(alu_aluop[d]), 32'(last_op[d]));
        if (!exp_err) begin
            for (int k = 0; k < settleOf(d); k++) begin
                checkOutput("rsp_valid_settling", d, 32'(rsp_valid[d]), 32'd0);
                checkOutput("req_ready_settling", d, 32'(req_ready[d]), 32'd0);
                rsp_ready[d] = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        rsp_ready[d] = 1'b0;
        checkOutput("rsp_valid", d, 32'(rsp_valid[d]), 32'd1);
        checkOutput("rsp_result", d, rsp_result[d], exp_res);
        checkOutput("rsp_tag", d, 32'(rsp_tag[d]), 32'(tag));
        checkOutput("rsp_err", d, 32'(rsp_err[d]), 32'(exp_err));
        checkOutput("req_ready_in_resp", d, 32'(req_ready[d]), 32'd0);
        for (int s = 0; s < stall; s++) begin
            req_valid[d] = 1'b1; req_in_1[d] = $urandom; req_aluop[d] = 5'd2;
            perturb[d] = $urandom | 32'd1;
            @(negedge clk);
            checkOutput("stall_rsp_valid", d, 32'(rsp_valid[d]), 32'd1);
            checkOutput("stall_rsp_result", d, rsp_result[d], exp_res);
            checkOutput("stall_req_ready", d, 32'(req_ready[d]), 32'd0);
            checkOutput("stall_alu_in_1", d, alu_in_1[d], last_a[d]);
        end
        req_valid[d] = 1'b0; perturb[d] = 32'd0; rsp_ready[d] = 1'b1;
        @(negedge clk);
        exp_count[d] = (exp_count[d] + 1) % countMod(d);
        checkOutput("rsp_valid_after_hs", d, 32'(rsp_valid[d]), 32'd0);
        checkOutput("req_ready_after_hs", d, 32'(req_ready[d]), 32'd1);
        checkOutput("op_count", d, 32'(op_count[d]), 32'(exp_count[d]));
        rsp_ready[d] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[11];
        int   prev_accept;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_in_1[d] = 32'd0; req_in_2[d] = 32'd0;
            req_aluop[d] = 5'd0; req_tag[d] = 4'd0; rsp_ready[d] = 1'b0; perturb[d] = 32'd0;
            last_accept[d] = 0;
        end
        @(negedge clk);
        resetDut(0);
        resetDut(1);

        // Directed table on the settle-1 instance: basic op, opcode edges, backpressure.
        vecs[0]  = '{32'd5, 32'd6, 5'd1, 4'd3, 0, 1'b0, 32'd11};
        vecs[1]  = '{32'd9, 32'd9, 5'd3, 4'd7, 0, 1'b1, 32'd0};
        vecs[2]  = '{32'd5, 32'd6, 5'd1, 4'd2, 5, 1'b0, 32'd11};
        vecs[3]  = '{32'd100, 32'd200, 5'd2, 4'd1, 0, 1'b0, 32'd300};
        vecs[4]  = '{32'd1, 32'd1, 5'd0, 4'd4, 1, 1'b1, 32'd0};
        vecs[5]  = '{32'hFFFF_FFFF, 32'd1, 5'd5, 4'd5, 0, 1'b0, 32'd0};
        vecs[6]  = '{32'd3, 32'd4, 5'd4, 4'd6, 0, 1'b1, 32'd0};
        vecs[7]  = '{32'd10, 32'd20, 5'd16, 4'd8, 2, 1'b0, 32'd30};
        vecs[8]  = '{32'd7, 32'd7, 5'd17, 4'd9, 0, 1'b1, 32'd0};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 5'd31, 4'd10, 0, 1'b1, 32'd0};
        vecs[10] = '{32'h1234_5678, 32'h1111_1111, 5'd12, 4'd11, 0, 1'b0, 32'h2345_6789};
        for (int i = 0; i < 11; i++)
            applyStimulus(0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag,
                          vecs[i].stall, vecs[i].exp_err, vecs[i].exp_res);

        // Reset while the settle-4 instance is mid-operation: the request must vanish.
        @(negedge clk);
        req_valid[1] = 1'b1; req_in_1[1] = 32'd7; req_in_2[1] = 32'd8;
        req_aluop[1] = 5'd16; req_tag[1] = 4'd5; rsp_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        checkOutput("settle_alu_in_1", 1, alu_in_1[1], 32'd7);
        @(negedge clk);
        resetDut(1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("dropped_no_rsp", 1, 32'(rsp_valid[1]), 32'd0);
        end
        checkOutput("dropped_op_count", 1, 32'(op_count[1]), 32'd0);

        // Settle-4 latency: 5 + 5 under opcode 16.
        applyStimulus(1, 32'd5, 32'd5, 5'd16, 4'd12, 0, 1'b0, 32'd10);

        // 17 back-to-back operations on the 4-bit counter; accepts are SETTLE+2 apart.
        resetDut(0);
        for (int i = 1; i <= 17; i++) begin
            prev_accept = last_accept[0];
            applyStimulus(0, 32'(i), 32'(2 * i), 5'd1, 4'(i), 0, 1'b0, 32'(3 * i));
            if (i > 1) checkOutput("b2b_accept_gap", 0, 32'(last_accept[0] - prev_accept), 32'd3);
        end
        checkOutput("op_count_wrapped", 0, 32'(op_count[0]), 32'd1);

        // Randomized traffic judged by the model: adder result for legal opcodes, error otherwise.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                logic [31:0] a, b;
                logic [4:0]  op;
                a  = $urandom;
                b  = $urandom;
                op = 5'($urandom_range(0, 31));
                applyStimulus(d, a, b, op, 4'($urandom), $urandom_range(0, 3),
                              !isLegal(op), isLegal(op) ? a + b : 32'd0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
